// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the data-memory responder.
// Strobe legality and address range checks live here.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  localparam int N_LEGAL_STRB = 7;

  localparam logic [3:0] LEGAL_STRB [N_LEGAL_STRB] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic strb_legal(input logic [3:0] strb);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_STRB; i++) begin
      if (strb == LEGAL_STRB[i]) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic addr_in_range(
    input logic [31:0] addr,
    input logic [31:0] base,
    input int unsigned depth
  );
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> 2) < depth);
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Four byte-lane single-port RAM, synchronous read, per-lane write.
// Read-first on a write cycle; contents are never reset.
module dmem_byte_ram #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we[g]) mem[addr] <= wdata[8*g +: 8];
        q <= mem[addr];
      end
    end

    assign rdata[8*g +: 8] = q;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave behind the LSU: one outstanding word access,
// fixed read latency, fault response for bad address or strobe.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e state;
  logic [2:0]  cnt;
  logic        rsp_load;

  logic          accept;
  logic          in_range;
  logic          strb_ok;
  logic          acc_err;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  assign accept   = req_valid && req_ready;
  assign in_range = addr_in_range(req_addr, BASE_ADDR, DEPTH_WORDS);
  assign strb_ok  = !req_we || strb_legal(req_wstrb);
  assign acc_err  = !in_range || !strb_ok;
  assign ram_en   = accept && !acc_err;
  assign ram_we   = (ram_en && req_we) ? req_wstrb : 4'b0000;
  assign ram_addr = AW'((req_addr - BASE_ADDR) >> 2);

  // Store commits and load reads both happen on the accept edge.
  dmem_byte_ram #(
    .DEPTH (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_load  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            rsp_err   <= acc_err;
            rsp_load  <= !req_we && !acc_err;
            if (RD_LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= 3'(RD_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_load  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM output register holds while no new access is accepted.
  assign rsp_rdata = (rsp_valid && rsp_load) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three latency variants behind one driver,
// scoreboard queue of expected responses from a word-level memory model.
module tb_dmem_responder;

  localparam int DEPTH = 4096;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b1;
  logic [1:0]  sel = 2'd0;

  logic        rv [3];
  logic        rr [3];
  logic        vv [3];
  logic [31:0] rd [3];
  logic        er [3];

  logic        req_ready_m;
  logic        rsp_valid_m;
  logic        rsp_err_m;
  logic [31:0] rsp_rdata_m;

  int   cyc = 0;
  int   n_asserts = 0;
  int   n_fail = 0;
  exp_t exp_q [$];
  logic [31:0] mem_m [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int k = 0; k < 3; k++) rv[k] = req_valid && (sel == 2'(k));
  end

  assign req_ready_m = rr[sel];
  assign rsp_valid_m = vv[sel];
  assign rsp_err_m   = er[sel];
  assign rsp_rdata_m = rd[sel];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(vv[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_err(er[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(3), .BASE_ADDR(32'h0)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(vv[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_err(er[1])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(4), .BASE_ADDR(32'h0)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rr[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(vv[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_err(er[2])
  );

  function automatic logic legal_strb_m(input logic [3:0] s);
    case (s)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model_expect(
    input logic we, input logic [31:0] addr,
    input logic [3:0] strb, input logic [31:0] data
  );
    exp_t e;
    int key;
    logic [31:0] w;
    e.err = 1'b0;
    e.rdata = 32'h0;
    if (addr >= 32'(DEPTH * 4) || (we && !legal_strb_m(strb))) begin
      e.err = 1'b1;
      return e;
    end
    key = int'(sel) * 8192 + int'(addr >> 2);
    w = mem_m.exists(key) ? mem_m[key] : 32'h0;
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
      mem_m[key] = w;
    end else begin
      e.rdata = w;
    end
    return e;
  endfunction

  task automatic do_txn(
    input logic we, input logic [31:0] addr,
    input logic [3:0] strb, input logic [31:0] data,
    output int lat, output int acc_cyc, output logic [31:0] rdata_o
  );
    int guard;
    exp_t e;
    guard = 0;
    while (!req_ready_m && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!req_ready_m) begin
      n_asserts++; n_fail++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready_m);
    end
    req_we = we; req_addr = addr; req_wstrb = strb; req_wdata = data;
    req_valid = 1'b1;
    exp_q.push_back(model_expect(we, addr, strb, data));
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid_m && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata_o = rsp_rdata_m;
    n_asserts++;
    if (!rsp_valid_m) begin
      n_fail++;
      $display("FAIL rsp_timeout: addr=%h rsp_valid=%b required 1", addr, rsp_valid_m);
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    if (rsp_rdata_m !== e.rdata || rsp_err_m !== e.err) begin
      n_fail++;
      $display("FAIL scoreboard: addr=%h we=%b got rdata=%h err=%b required rdata=%h err=%b",
               addr, we, rsp_rdata_m, rsp_err_m, e.rdata, e.err);
    end
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_asserts++;
      if (rr[k] !== 1'b0 || vv[k] !== 1'b0 || rd[k] !== 32'h0 || er[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: ready=%b valid=%b rdata=%h err=%b required 0 0 0 0",
                 k, rr[k], vv[k], rd[k], er[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      n_asserts++;
      if (rr[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release_ready[%0d]: got %b required 1", k, rr[k]);
      end
    end
  endtask

  task automatic test_store_load;
    int lat, acc;
    logic [31:0] r;
    sel = 2'd0;
    do_txn(1'b1, 32'h0, 4'hF, 32'hFEDCBA98, lat, acc, r);
    do_txn(1'b0, 32'h0, 4'h0, 32'h0, lat, acc, r);
    n_asserts++;
    if (lat !== 1 || r !== 32'hFEDCBA98) begin
      n_fail++;
      $display("FAIL load_l1: lat=%0d rdata=%h required lat=1 rdata=fedcba98", lat, r);
    end
  endtask

  task automatic test_byte_merge;
    int lat, acc;
    logic [31:0] r;
    sel = 2'd0;
    do_txn(1'b1, 32'h4, 4'b1111, 32'h11223344, lat, acc, r);
    do_txn(1'b1, 32'h5, 4'b0010, 32'h00007800, lat, acc, r);
    do_txn(1'b1, 32'h6, 4'b1100, 32'hEF010000, lat, acc, r);
    do_txn(1'b0, 32'h4, 4'h0, 32'h0, lat, acc, r);
    n_asserts++;
    if (r !== 32'hEF017844) begin
      n_fail++;
      $display("FAIL byte_merge: got %h required ef017844", r);
    end
  endtask

  task automatic test_backpressure;
    int lat, acc, hs;
    logic [31:0] r;
    exp_t e;
    sel = 2'd1;
    rsp_ready = 1'b1;
    do_txn(1'b1, 32'h10, 4'hF, 32'h13572468, lat, acc, r);
    rsp_ready = 1'b0;
    req_we = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0; req_valid = 1'b1;
    exp_q.push_back(model_expect(1'b0, 32'h10, 4'h0, 32'h0));
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid_m && lat < 20) begin
      n_asserts++;
      if (req_ready_m !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready_wait: got %b required 0", req_ready_m);
      end
      @(posedge clk); #1;
      lat++;
    end
    n_asserts++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d required 3", lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_asserts++;
      if (rsp_valid_m !== 1'b1 || rsp_rdata_m !== 32'h13572468 || req_ready_m !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: valid=%b rdata=%h ready=%b required 1 13572468 0",
                 rsp_valid_m, rsp_rdata_m, req_ready_m);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    e = exp_q.pop_front();
    n_asserts++;
    if (rsp_rdata_m !== e.rdata || rsp_err_m !== e.err) begin
      n_fail++;
      $display("FAIL bp_scoreboard: got %h/%b required %h/%b",
               rsp_rdata_m, rsp_err_m, e.rdata, e.err);
    end
    @(posedge clk); #1;
    hs = cyc;
    n_asserts++;
    if (req_ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_after: got %b required 1", req_ready_m);
    end
    do_txn(1'b0, 32'h10, 4'h0, 32'h0, lat, acc, r);
    n_asserts++;
    if (acc !== hs + 1) begin
      n_fail++;
      $display("FAIL bp_reaccept: accept cycle %0d required %0d", acc, hs + 1);
    end
  endtask

  task automatic test_errors;
    int lat, acc;
    logic [31:0] r;
    sel = 2'd0;
    do_txn(1'b1, 32'h20, 4'hF, 32'hA5A5A5A5, lat, acc, r);
    do_txn(1'b1, 32'(DEPTH * 4), 4'hF, 32'h12345678, lat, acc, r);
    do_txn(1'b1, 32'h20, 4'b0101, 32'hFFFFFFFF, lat, acc, r);
    do_txn(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, lat, acc, r);
    do_txn(1'b0, 32'h20, 4'h0, 32'h0, lat, acc, r);
    n_asserts++;
    if (r !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL bad_strb_nowrite: got %h required a5a5a5a5", r);
    end
    do_txn(1'b0, 32'h0001_0000, 4'h0, 32'h0, lat, acc, r);
    n_asserts++;
    if (lat !== 1 || r !== 32'h0) begin
      n_fail++;
      $display("FAIL oor_load: lat=%0d rdata=%h required 1 00000000", lat, r);
    end
    do_txn(1'b1, 32'(DEPTH * 4 - 4), 4'hF, 32'h0BADF00D, lat, acc, r);
    do_txn(1'b0, 32'(DEPTH * 4 - 4), 4'h0, 32'h0, lat, acc, r);
  endtask

  task automatic test_reset_abort;
    int lat, acc;
    logic [31:0] r;
    sel = 2'd2;
    do_txn(1'b1, 32'h8, 4'hF, 32'hDEADBEEF, lat, acc, r);
    req_we = 1'b0; req_addr = 32'h8; req_wstrb = 4'h0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_asserts++;
    if (req_ready_m !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_wait_ready: got %b required 0", req_ready_m);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_asserts++;
    if (rsp_valid_m !== 1'b0 || req_ready_m !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_reset: valid=%b ready=%b required 0 0", rsp_valid_m, req_ready_m);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_asserts++;
    if (req_ready_m !== 1'b1 || rsp_valid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_release: ready=%b valid=%b required 1 0", req_ready_m, rsp_valid_m);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_asserts++;
      if (rsp_valid_m !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_stale_rsp: valid=%b required 0", rsp_valid_m);
      end
    end
    do_txn(1'b0, 32'h8, 4'h0, 32'h0, lat, acc, r);
    n_asserts++;
    if (lat !== 4 || r !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL abort_readback: lat=%0d rdata=%h required 4 deadbeef", lat, r);
    end
  endtask

  task automatic test_back_to_back;
    int lat, acc, prev;
    logic [31:0] r, a;
    sel = 2'd0;
    rsp_ready = 1'b1;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      do_txn(1'b1, a, 4'hF, $urandom, lat, acc, r);
      if (prev >= 0) begin
        n_asserts++;
        if (acc - prev !== 2) begin
          n_fail++;
          $display("FAIL b2b_period: got %0d required 2", acc - prev);
        end
      end
      prev = acc;
      do_txn(1'b0, a, 4'h0, 32'h0, lat, acc, r);
      n_asserts++;
      if (acc - prev !== 2 || lat !== 1) begin
        n_fail++;
        $display("FAIL b2b_load: period=%0d lat=%0d required 2 1", acc - prev, lat);
      end
      prev = acc;
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_merge();
    test_backpressure();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    n_asserts++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
